fetch_pc_ctrl: RTL and testbench

//  Next-PC generator and F1/F2 fetch register for the 2-wide front end. Issues one 8-byte pair fetch per cycle to the

---
 rtl/fetch_pc_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_ctrl.sv
// Next-PC generator and F1/F2 fetch register for the 2-wide front end.
// Static backward-taken prediction, decode backpressure and execute redirects.
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic             imem_req_o,
  output logic [31:0]      imem_addr_o,
  input  logic [1:0]       branch_en_i,
  input  logic [1:0][31:0] imm_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      f2_pc_o,
  output logic [1:0]       slot_valid_o,
  output logic [1:0]       pred_taken_o,
  output logic [31:0]      pred_target_o,
  input  logic             ex_redirect_i,
  input  logic [31:0]      ex_target_i
);

  localparam int unsigned AW       = 32;
  localparam int unsigned PAIR_B   = 8;
  localparam int unsigned SLOT_B   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            f2_valid_q, f2_valid_d;
  logic [AW-1:0]   f2_pc_q, f2_pc_d;
  logic [AW-1:0]   pc_q, pc_d;

  logic [1:0]      raw_t_c;
  logic [1:0]      pt_c;
  logic [AW-1:0]   tgt_c;
  logic            adv_c;
  logic            req_c;
  logic [AW-1:0]   addr_c;

  // Static prediction on the F2 pair; slot 0 has priority.
  always_comb begin
    raw_t_c = branch_en_i & {imm_in_i[1][31], imm_in_i[0][31]} & {2{f2_valid_q}};
    pt_c    = {raw_t_c[1] & ~raw_t_c[0], raw_t_c[0]};
    tgt_c   = '0;
    if (raw_t_c[0]) begin
      tgt_c = f2_pc_q + imm_in_i[0];
    end else if (raw_t_c[1]) begin
      tgt_c = f2_pc_q + AW'(SLOT_B) + imm_in_i[1];
    end
    adv_c = ~f2_valid_q | out_ready_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ex_redirect_i) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:       state_d = RUN;
        RUN, STALL: state_d = adv_c ? RUN : STALL;
        default:    state_d = IDLE;
      endcase
    end
  end

  // Fetch request and decode-facing outputs; everything is forced low during reset.
  always_comb begin
    req_c         = 1'b0;
    addr_c        = '0;
    imem_req_o    = 1'b0;
    imem_addr_o   = '0;
    out_valid_o   = 1'b0;
    f2_pc_o       = '0;
    slot_valid_o  = '0;
    pred_taken_o  = '0;
    pred_target_o = '0;
    if (ex_redirect_i) begin
      req_c  = 1'b1;
      addr_c = ex_target_i & ~AW'(3);
    end else if (state_q == IDLE) begin
      req_c  = 1'b1;
      addr_c = RESET_PC;
    end else if (adv_c) begin
      req_c  = 1'b1;
      addr_c = (|pt_c) ? tgt_c : pc_q;
    end
    if (!rst_i) begin
      imem_req_o    = req_c;
      imem_addr_o   = addr_c;
      out_valid_o   = f2_valid_q & ~ex_redirect_i;
      f2_pc_o       = f2_pc_q;
      slot_valid_o  = {f2_valid_q & ~raw_t_c[0], f2_valid_q} & {2{~ex_redirect_i}};
      pred_taken_o  = pt_c & {2{~ex_redirect_i}};
      pred_target_o = tgt_c;
    end
  end

  always_comb begin
    f2_valid_d = f2_valid_q;
    f2_pc_d    = f2_pc_q;
    pc_d       = pc_q;
    if (req_c) begin
      f2_valid_d = 1'b1;
      f2_pc_d    = addr_c;
      pc_d       = addr_c + AW'(PAIR_B);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f2_valid_q <= 1'b0;
      f2_pc_q    <= '0;
      pc_q       <= RESET_PC;
    end else begin
      f2_valid_q <= f2_valid_d;
      f2_pc_q    <= f2_pc_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl: behavioural fetch model checked every cycle,
// plus literal expectations at the interesting points of the sequence.
module tb_fetch_pc_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] M16 = 32'hFFFF_FFF0;
  localparam logic [31:0] M8  = 32'hFFFF_FFF8;

  logic             clk = 1'b0;
  logic             rst;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [1:0]       branch_en;
  logic [1:0][31:0] imm_in;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      f2_pc;
  logic [1:0]       slot_valid;
  logic [1:0]       pred_taken;
  logic [31:0]      pred_target;
  logic             ex_redirect;
  logic [31:0]      ex_target;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.RESET_PC(RPC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .branch_en_i(branch_en), .imm_in_i(imm_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .f2_pc_o(f2_pc), .slot_valid_o(slot_valid),
    .pred_taken_o(pred_taken), .pred_target_o(pred_target),
    .ex_redirect_i(ex_redirect), .ex_target_i(ex_target)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: "started" = past the post-reset cycle, plus what sits in F2 and the next sequential pair.
  bit          m_started = 1'b0;
  bit          m_f2v     = 1'b0;
  logic [31:0] m_f2pc    = '0;
  logic [31:0] m_seq     = RPC;

  function automatic void predict(output logic [1:0] pt, output logic [31:0] tgt);
    pt  = 2'b00;
    tgt = '0;
    if (m_f2v && branch_en[0] && imm_in[0][31]) begin
      pt = 2'b01; tgt = m_f2pc + imm_in[0];
    end else if (m_f2v && branch_en[1] && imm_in[1][31]) begin
      pt = 2'b10; tgt = m_f2pc + 32'd4 + imm_in[1];
    end
  endfunction

  function automatic void fetch(output bit req, output logic [31:0] addr);
    logic [1:0]  pt;
    logic [31:0] tgt;
    predict(pt, tgt);
    req  = 1'b1;
    addr = '0;
    if (ex_redirect)                 addr = {ex_target[31:2], 2'b00};
    else if (!m_started)             addr = RPC;
    else if (!m_f2v || out_ready)    addr = (pt != 2'b00) ? tgt : m_seq;
    else                             req  = 1'b0;
  endfunction

  always @(posedge clk) begin
    bit          req;
    logic [31:0] addr;
    if (rst) begin
      m_started <= 1'b0; m_f2v <= 1'b0; m_f2pc <= '0; m_seq <= RPC;
    end else begin
      fetch(req, addr);
      if (req) begin
        m_started <= 1'b1; m_f2v <= 1'b1; m_f2pc <= addr; m_seq <= addr + 32'd8;
      end
    end
  end

  always @(negedge clk) begin
    bit          e_req;
    logic [31:0] e_addr, e_tgt;
    logic [1:0]  e_pt;
    bit          e_ov;
    if (rst) begin
      chk("m_req",  32'(imem_req), 32'd0);
      chk("m_addr", imem_addr, 32'd0);
      chk("m_ov",   32'(out_valid), 32'd0);
      chk("m_pc",   f2_pc, 32'd0);
      chk("m_sv",   32'(slot_valid), 32'd0);
      chk("m_pt",   32'(pred_taken), 32'd0);
      chk("m_tgt",  pred_target, 32'd0);
    end else begin
      fetch(e_req, e_addr);
      predict(e_pt, e_tgt);
      e_ov = m_f2v && !ex_redirect;
      chk("m_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("m_addr", imem_addr, e_addr);
      chk("m_ov",  32'(out_valid), 32'(e_ov));
      chk("m_pc",  f2_pc, m_f2pc);
      chk("m_sv",  32'(slot_valid), !e_ov ? 32'd0 : (e_pt[0] ? 32'd1 : 32'd3));
      chk("m_pt",  32'(pred_taken), ex_redirect ? 32'd0 : 32'(e_pt));
      chk("m_tgt", pred_target, e_tgt);
    end
  end

  task automatic drive(input bit r, input bit rdy, input logic [1:0] ben,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input bit redir, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    rst = r; out_ready = rdy; branch_en = ben;
    imm_in[0] = i0; imm_in[1] = i1; ex_redirect = redir; ex_target = tgt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1; branch_en = '0; imm_in = '0;
    ex_redirect = 1'b0; ex_target = '0;

    drive(1, 1, 2'b00, 0, 0, 0, 0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    drive(1, 1, 2'b00, 0, 0, 0, 0);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("idle_addr", imem_addr, 32'h100);
    chk("idle_ov", 32'(out_valid), 32'd0);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("seq1_addr", imem_addr, 32'h108);
    chk("seq1_pc", f2_pc, 32'h100);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("seq2_addr", imem_addr, 32'h110);
    chk("seq2_pc", f2_pc, 32'h108);

    drive(0, 1, 2'b00, 0, 0, 1, 32'h200);
    chk("redir_ov", 32'(out_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h200);
    drive(0, 1, 2'b01, M16, 0, 0, 0);
    chk("bk0_pt", 32'(pred_taken), 32'd1);
    chk("bk0_sv", 32'(slot_valid), 32'd1);
    chk("bk0_tgt", pred_target, 32'h1F0);
    chk("bk0_addr", imem_addr, 32'h1F0);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("bk0_next_pc", f2_pc, 32'h1F0);
    chk("bk0_next_addr", imem_addr, 32'h1F8);

    drive(0, 1, 2'b00, 0, 0, 1, 32'h200);
    drive(0, 1, 2'b10, 0, 32'd32, 0, 0);
    chk("fw1_pt", 32'(pred_taken), 32'd0);
    chk("fw1_addr", imem_addr, 32'h208);
    drive(0, 1, 2'b00, 0, 0, 1, 32'h200);
    drive(0, 1, 2'b10, 0, M8, 0, 0);
    chk("bk1_tgt", pred_target, 32'h1FC);
    chk("bk1_pt", 32'(pred_taken), 32'd2);
    chk("bk1_sv", 32'(slot_valid), 32'd3);
    chk("bk1_addr", imem_addr, 32'h1FC);
    drive(0, 1, 2'b00, 0, 0, 1, 32'h200);
    drive(0, 1, 2'b11, M16, M8, 0, 0);
    chk("both_pt", 32'(pred_taken), 32'd1);
    chk("both_tgt", pred_target, 32'h1F0);
    drive(0, 1, 2'b00, 0, 0, 1, 32'h200);
    drive(0, 1, 2'b11, 32'd16, M8, 0, 0);
    chk("s1only_pt", 32'(pred_taken), 32'd2);
    chk("s1only_tgt", pred_target, 32'h1FC);

    drive(0, 1, 2'b00, 0, 0, 1, 32'h300);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 2'b00, 0, 0, 0, 0);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_pc", f2_pc, 32'h300);
      chk("stall_ov", 32'(out_valid), 32'd1);
    end
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("release_addr", imem_addr, 32'h308);

    drive(0, 1, 2'b00, 0, 0, 1, 32'h300);
    drive(0, 0, 2'b01, M16, 0, 0, 0);
    chk("stall_br_req", 32'(imem_req), 32'd0);
    chk("stall_br_pt", 32'(pred_taken), 32'd1);
    drive(0, 1, 2'b01, M16, 0, 0, 0);
    chk("stall_br_addr", imem_addr, 32'h2F0);

    drive(0, 1, 2'b00, 0, 0, 1, 32'h300);
    drive(0, 0, 2'b00, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 1, 32'h407);
    chk("sq_ov", 32'(out_valid), 32'd0);
    chk("sq_req", 32'(imem_req), 32'd1);
    chk("sq_addr", imem_addr, 32'h404);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("sq_pc", f2_pc, 32'h404);
    chk("sq_ov2", 32'(out_valid), 32'd1);

    drive(0, 1, 2'b00, 0, 0, 1, 32'hFFFF_FFF8);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("wrap_pc", f2_pc, 32'hFFFF_FFF8);
    chk("wrap_addr", imem_addr, 32'h0);
    drive(0, 1, 2'b00, 0, 0, 1, 32'h4);
    drive(0, 1, 2'b01, M16, 0, 0, 0);
    chk("wrap_tgt", pred_target, 32'hFFFF_FFF4);

    drive(0, 1, 2'b00, 0, 0, 0, 0);
    drive(1, 1, 2'b00, 0, 0, 0, 0);
    chk("midrst_ov", 32'(out_valid), 32'd0);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("midrst_idle_ov", 32'(out_valid), 32'd0);
    chk("midrst_idle_addr", imem_addr, 32'h100);
    drive(0, 1, 2'b00, 0, 0, 0, 0);
    chk("midrst_pc", f2_pc, 32'h100);
    chk("midrst_ov2", 32'(out_valid), 32'd1);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
